// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the word-wide UART transmitter.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 868;
    localparam int NUM_BYTES_DEF    = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_DONE = 2'd2
    } word_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with bit timer; a start in the last stop-bit cycle chains
// the next frame with no idle gap.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       serial,
    output logic       busy,
    output logic       done
);

    localparam int              TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]   TIMER_MAX = TW'(CLKS_PER_BIT - 1);

    tx_state_t       state_q, state_d;
    logic [TW-1:0]   timer_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            serial_q;
    logic            bit_end;
    logic            load;

    assign bit_end = (timer_q == TIMER_MAX);
    assign done    = (state_q == STOP) && bit_end;
    assign busy    = (state_q != IDLE);
    assign load    = start && ((state_q == IDLE) || done);
    assign serial  = serial_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && (bit_idx_q == 3'd7)) state_d = STOP;
            STOP:    if (bit_end) state_d = load ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (load) begin
                timer_q   <= '0;
                bit_idx_q <= '0;
                shift_q   <= data;
                serial_q  <= 1'b0;
            end else if (state_q != IDLE) begin
                if (bit_end) begin
                    timer_q <= '0;
                    // serial_q is loaded one bit ahead so the line changes exactly on the period boundary
                    case (state_q)
                        START: serial_q <= shift_q[0];
                        DATA: begin
                            if (bit_idx_q == 3'd7) begin
                                serial_q <= 1'b1;
                            end else begin
                                serial_q  <= shift_q[1];
                                shift_q   <= shift_q >> 1;
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end
                        default: serial_q <= 1'b1;
                    endcase
                end else begin
                    timer_q <= timer_q + TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/word_uart_tx.sv
// Sends a NUM_BYTES-wide word as back-to-back 8N1 frames, byte 0 first.
module word_uart_tx
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter  int NUM_BYTES    = NUM_BYTES_DEF,
    localparam int IW           = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_tx_valid,
    input  logic [8*NUM_BYTES-1:0] i_tx_data,
    output logic                   o_tx_ready,
    output logic                   o_tx_serial,
    output logic                   o_tx_active,
    output logic                   o_tx_done,
    output logic [IW-1:0]          o_byte_idx
);

    word_state_t            wstate_q, wstate_d;
    logic [8*NUM_BYTES-1:0] word_q;
    logic [IW-1:0]          byte_idx_q;
    logic                   ready_q, active_q, done_q;
    logic                   accept, last_byte, next_byte;
    logic                   byte_start, byte_busy, byte_done;
    logic [7:0]             byte_data;

    assign accept     = i_tx_valid && ready_q;
    assign last_byte  = (byte_idx_q == IW'(NUM_BYTES - 1));
    assign next_byte  = byte_done && !last_byte;
    assign byte_start = accept || next_byte;
    // Byte 0 goes straight from the input; later bytes come off the bottom of the shifting word register
    assign byte_data  = accept ? i_tx_data[7:0] : word_q[7:0];

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk   (i_clk),
        .rst   (i_rst),
        .start (byte_start),
        .data  (byte_data),
        .serial(o_tx_serial),
        .busy  (byte_busy),
        .done  (byte_done)
    );

    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE: if (accept) wstate_d = W_SEND;
            W_SEND: begin
                if (byte_done && last_byte) wstate_d = W_DONE;
                else if (!byte_busy)        wstate_d = W_IDLE;
            end
            W_DONE:  wstate_d = accept ? W_SEND : W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wstate_q   <= W_IDLE;
            word_q     <= '0;
            byte_idx_q <= '0;
            ready_q    <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            ready_q  <= (wstate_d != W_SEND);
            active_q <= (wstate_d == W_SEND);
            done_q   <= (wstate_d == W_DONE);
            if (accept) begin
                word_q     <= i_tx_data >> 8;
                byte_idx_q <= '0;
            end else if (next_byte) begin
                word_q     <= word_q >> 8;
                byte_idx_q <= byte_idx_q + IW'(1);
            end
        end
    end

    assign o_tx_ready  = ready_q;
    assign o_tx_active = active_q;
    assign o_tx_done   = done_q;
    assign o_byte_idx  = byte_idx_q;

endmodule

// File: doc/word_uart_tx.md
WORD_UART_TX -- requirements
Module: word_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, i_clk cycles per UART bit (100 MHz / 115200 baud); minimum legal value 2.
REQ-002 Parameter NUM_BYTES, default 32, bytes per transmitted word.
REQ-003 Port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port i_rst  input  1  asynchronous, active-high reset.
REQ-005 Port i_tx_valid  input  1  upstream word valid.
REQ-006 Port i_tx_data  input  8*NUM_BYTES  word to send (256 bits at default), e.g. the shift-register output.
REQ-007 Port o_tx_ready  output  1  block idle, will accept a word.
REQ-008 Port o_tx_serial  output  1  UART TX line, 8N1, idle high.
REQ-009 Port o_tx_active  output  1  high while any frame of the word is on the line.
REQ-010 Port o_tx_done  output  1  one-cycle pulse after the last stop bit of the last byte.
REQ-011 Port o_byte_idx  output  clog2(NUM_BYTES)  index of the byte currently being sent.

Function
REQ-012 Word accepted on the rising edge where i_tx_valid && o_tx_ready; i_tx_data captured into an internal word register on that edge.
REQ-013 o_tx_ready deasserts the cycle after acceptance and stays low until o_tx_done pulses.
REQ-014 i_tx_valid and i_tx_data are ignored while o_tx_ready is low; no queuing.
REQ-015 Byte order: byte 0 = i_tx_data[7:0] sent first, byte NUM_BYTES-1 last; bit order within a byte is LSB first.
REQ-016 Frame = 1 start bit (0), 8 data bits, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-017 FSM states IDLE, START, DATA, STOP, DONE; IDLE->START on accept; START->DATA after CLKS_PER_BIT; DATA->STOP after 8 bit periods; STOP->START (next byte) or STOP->DONE (last byte) after CLKS_PER_BIT; DONE->IDLE after one cycle.
REQ-018 No idle gap between bytes: the start bit of byte n+1 follows the stop bit of byte n directly.
REQ-019 o_tx_serial drives the start bit from the cycle after acceptance; total time from acceptance to o_tx_done = NUM_BYTES*10*CLKS_PER_BIT + 1 cycles.
REQ-020 o_tx_done is high only in DONE; o_tx_ready is high in IDLE and DONE, so a new word can be accepted in the same cycle as o_tx_done.
REQ-021 o_tx_active is high in START, DATA and STOP only.
REQ-022 Bit-timer counts 0..CLKS_PER_BIT-1 and wraps; bit-index counts 0..7; byte-index counts 0..NUM_BYTES-1; none overflows or wraps past its bound.
REQ-023 All outputs are registered; o_tx_serial is glitch-free.

Reset
REQ-024 Asserting i_rst at any time, including mid-frame, immediately forces IDLE, o_tx_serial=1, o_tx_ready=1, o_tx_active=0, o_tx_done=0, o_byte_idx=0, and clears all counters and the word register.
REQ-025 A partially sent word is discarded on reset; no frame resumes after deassertion.
REQ-026 First acceptance is possible on the first rising edge after i_rst deasserts.

Structure
REQ-027 The FSM state encoding and the default CLKS_PER_BIT/NUM_BYTES constants are defined in the shared package uart_pkg.
REQ-028 A single sub-module, uart_tx_byte (bit timer + 8N1 byte serializer with start/busy/done), is instantiated once; word_uart_tx sequences the bytes.

Verification (CLKS_PER_BIT=4, NUM_BYTES=32)
REQ-029 Accept i_tx_data = 256'h...0201 (byte k = k+1) -> decoded line bytes 0x01,0x02,...,0x20 in order; o_tx_done pulses at cycle 1281 after acceptance.
REQ-030 Send all-0x55 word -> line toggles every 4 cycles inside data bits, stop bits high, no inter-byte gap; o_byte_idx steps 0..31.
REQ-031 Hold i_tx_valid high with a changing i_tx_data during transmission -> o_tx_ready low, line output unaffected, exactly one word sent.
REQ-032 Present a second word in the o_tx_done cycle -> accepted that edge; start bit of its byte 0 appears on the next cycle.
REQ-033 Pulse i_rst in the middle of byte 5's data bits -> o_tx_serial=1 and o_tx_ready=1 immediately; no o_tx_done; the next word sends cleanly from byte 0.
REQ-034 Loop o_tx_serial into the existing UART receiver (same CLKS_PER_BIT) -> all 32 received bytes match the word, no framing errors.
